// File: rtl/spart_pkg.sv
// Shared constants and types for the SPART MMIO bridge.
// SPART_PARITY_EN adds the PARITY state to the serial FSM encoding.
package spart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_IDLE  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_OVERRUN  = 4;
    localparam int ST_FRAME    = 5;
    localparam int ST_PARITY   = 6;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;
    localparam int CTRL_LOOP  = 2;

    localparam logic [31:0] RD_EMPTY = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef SPART_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } ser_state_e;

    // Accepted request, held through the ready cycle so its side effects land at the end of it.
    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        pop;
        logic [2:0]  clr;
    } req_t;

endpackage

// File: rtl/spart_fifo.sv
// Synchronous FIFO with first-word fall-through read; a pop frees a slot for a same-cycle push.
module spart_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            if (do_push != do_pop) cnt_q <= do_push ? cnt_q + 1'b1 : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spart_mmio_bridge.sv
// Memory-mapped SPART: request handshake, TX/RX FIFOs, x16 baud generator, serial TX/RX.
// Define SPART_PARITY_EN for an even parity bit after the data bits in both directions.
module spart_mmio_bridge
    import spart_pkg::*;
#(
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_rw_data,
    input  logic        io_valid_data,
    output logic        io_ready_data,
    input  logic [27:0] mem_addr,
    input  logic [31:0] io_wr_data,
    output logic [31:0] io_rd_data,
    input  logic        rxd,
    output logic        txd,
    output logic        irq
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic             tick, accept, tx_push, rx_pop, div_wr, ctrl_wr;
    logic [DIV_W-1:0] div_q, bcnt_q;
    logic [2:0]       ctrl_q, clr;
    logic             rdy_q, irq_q, ovr_q, fe_q, pe_q, ovr_set, fe_set, pe_set;
    logic [31:0]      rdata_q, rdata_d, status;
    req_t             req_q, req_d;
    logic             tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
    logic [7:0]       tx_rdata, rx_rdata;
    logic [TCW-1:0]   tx_cnt;
    logic [RCW-1:0]   rx_cnt;
    ser_state_e       tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [3:0]       tx_tc_q, tx_tc_d, rx_tc_q, rx_tc_d;
    logic [2:0]       tx_bc_q, tx_bc_d, rx_bc_q, rx_bc_d;
    logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic             tx_par_q, tx_par_d, rx_par_q, rx_par_d, txd_q, txd_d, tx_idle, tx_end;
    logic [1:0]       rx_sync_q;
    logic             rx_prev_q, rx_s, rx_samp, rx_done;
    logic             unused_ok;

    assign unused_ok = ^{mem_addr[27:2], req_q.wdata, tx_par_q, rx_par_q};

    // A DATA write into a full TX FIFO is simply not accepted until a slot frees.
    assign accept  = io_valid_data && !rdy_q &&
                     !(io_rw_data && mem_addr[1:0] == REG_DATA && tx_full);
    assign tx_push = rdy_q && req_q.wr && req_q.addr == REG_DATA;
    assign div_wr  = rdy_q && req_q.wr && req_q.addr == REG_DIV;
    assign ctrl_wr = rdy_q && req_q.wr && req_q.addr == REG_CTRL;
    assign rx_pop  = rdy_q && req_q.pop;
    assign clr     = rdy_q ? req_q.clr : 3'b000;
    assign tick    = (bcnt_q == '0);
    assign tx_idle = (tx_st_q == S_IDLE) && tx_empty;

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_IDLE]  = tx_idle;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_OVERRUN]  = ovr_q;
        status[ST_FRAME]    = fe_q;
        status[ST_PARITY]   = pe_q;
        status[15:8]        = 8'(rx_cnt);
        status[23:16]       = 8'(tx_cnt);
    end

    // Sticky bits are cleared only where the returned value actually showed them.
    always_comb begin
        rdata_d     = '0;
        req_d       = '0;
        req_d.wr    = io_rw_data;
        req_d.addr  = mem_addr[1:0];
        req_d.wdata = io_wr_data;
        if (!io_rw_data) begin
            case (mem_addr[1:0])
                REG_DATA: begin
                    rdata_d   = rx_empty ? RD_EMPTY : {24'b0, rx_rdata};
                    req_d.pop = !rx_empty;
                end
                REG_STATUS: begin
                    rdata_d   = status;
                    req_d.clr = status[ST_PARITY:ST_OVERRUN];
                end
                REG_DIV: rdata_d = 32'(div_q);
                default: rdata_d = {29'b0, ctrl_q};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= '0;
            div_q   <= DIV_W'(DIV_RESET);
            bcnt_q  <= DIV_W'(DIV_RESET);
            ctrl_q  <= '0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            rdy_q <= accept;
            if (accept) begin
                rdata_q <= rdata_d;
                req_q   <= req_d;
            end
            if (div_wr) begin
                div_q  <= req_q.wdata[DIV_W-1:0];
                bcnt_q <= req_q.wdata[DIV_W-1:0];
            end else if (tick) begin
                bcnt_q <= div_q;
            end else begin
                bcnt_q <= bcnt_q - 1'b1;
            end
            if (ctrl_wr) ctrl_q <= req_q.wdata[2:0];
            ovr_q <= ovr_set | (ovr_q & ~clr[0]);
            fe_q  <= fe_set  | (fe_q  & ~clr[1]);
            pe_q  <= pe_set  | (pe_q  & ~clr[2]);
            irq_q <= (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_TX_IE] & tx_idle);
        end
    end

    spart_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk(clk), .rst_ni(rst), .push_i(tx_push), .wdata_i(req_q.wdata[7:0]),
        .pop_i(tx_pop), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
    );

    spart_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk(clk), .rst_ni(rst), .push_i(rx_push), .wdata_i(rx_sh_q),
        .pop_i(rx_pop), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st_q  <= S_IDLE;
            tx_tc_q  <= '0;
            tx_bc_q  <= '0;
            tx_sh_q  <= '0;
            tx_par_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_tc_q  <= tx_tc_d;
            tx_bc_q  <= tx_bc_d;
            tx_sh_q  <= tx_sh_d;
            tx_par_q <= tx_par_d;
            txd_q    <= txd_d;
        end
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_tc_d  = tick ? tx_tc_q + 4'd1 : tx_tc_q;
        tx_bc_d  = tx_bc_q;
        tx_sh_d  = tx_sh_q;
        tx_par_d = tx_par_q;
        tx_end   = tick && (tx_tc_q == 4'd15);
        case (tx_st_q)
            S_IDLE: if (!tx_empty) begin
                tx_st_d  = S_START;
                tx_tc_d  = '0;
                tx_bc_d  = '0;
                tx_sh_d  = tx_rdata;
                tx_par_d = ^tx_rdata;
            end
            S_START: if (tx_end) tx_st_d = S_DATA;
            S_DATA: if (tx_end) begin
                tx_sh_d = {1'b0, tx_sh_q[7:1]};
                tx_bc_d = tx_bc_q + 3'd1;
`ifdef SPART_PARITY_EN
                if (tx_bc_q == 3'd7) tx_st_d = S_PARITY;
`else
                if (tx_bc_q == 3'd7) tx_st_d = S_STOP;
`endif
            end
`ifdef SPART_PARITY_EN
            S_PARITY: if (tx_end) tx_st_d = S_STOP;
`endif
            S_STOP: if (tx_end) tx_st_d = S_IDLE;
            default: tx_st_d = S_IDLE;
        endcase
    end

    // txd is registered from the next state so the pin never glitches.
    always_comb begin
        tx_pop = (tx_st_q == S_IDLE) && !tx_empty;
        case (tx_st_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = tx_sh_d[0];
`ifdef SPART_PARITY_EN
            S_PARITY: txd_d = tx_par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    assign rx_s = rx_sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sync_q <= 2'b11;
            rx_prev_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_tc_q   <= '0;
            rx_bc_q   <= '0;
            rx_sh_q   <= '0;
            rx_par_q  <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], ctrl_q[CTRL_LOOP] ? txd_q : rxd};
            rx_prev_q <= rx_s;
            rx_st_q   <= rx_st_d;
            rx_tc_q   <= rx_tc_d;
            rx_bc_q   <= rx_bc_d;
            rx_sh_q   <= rx_sh_d;
            rx_par_q  <= rx_par_d;
        end
    end

    // Start bit is re-checked half a bit in; every later sample lands mid-bit, 16 ticks on.
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_tc_d  = tick ? rx_tc_q + 4'd1 : rx_tc_q;
        rx_bc_d  = rx_bc_q;
        rx_sh_d  = rx_sh_q;
        rx_par_d = rx_par_q;
        case (rx_st_q)
            S_IDLE: if (rx_prev_q && !rx_s) begin
                rx_st_d = S_START;
                rx_tc_d = '0;
            end
            S_START: if (rx_samp) begin
                rx_st_d = rx_s ? S_IDLE : S_DATA;
                rx_tc_d = '0;
                rx_bc_d = '0;
            end
            S_DATA: if (rx_samp) begin
                rx_sh_d = {rx_s, rx_sh_q[7:1]};
                rx_bc_d = rx_bc_q + 3'd1;
`ifdef SPART_PARITY_EN
                if (rx_bc_q == 3'd7) rx_st_d = S_PARITY;
`else
                if (rx_bc_q == 3'd7) rx_st_d = S_STOP;
`endif
            end
`ifdef SPART_PARITY_EN
            S_PARITY: if (rx_samp) begin
                rx_par_d = rx_s;
                rx_st_d  = S_STOP;
            end
`endif
            S_STOP: if (rx_samp) rx_st_d = S_IDLE;
            default: rx_st_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_samp = tick && (rx_tc_q == ((rx_st_q == S_START) ? 4'd7 : 4'd15));
        rx_done = (rx_st_q == S_STOP) && rx_samp;
        fe_set  = rx_done && !rx_s;
        ovr_set = rx_done && rx_s && rx_full && !rx_pop;
        rx_push = rx_done && rx_s && !ovr_set;
`ifdef SPART_PARITY_EN
        pe_set  = rx_done && rx_s && (rx_par_q != ^rx_sh_q);
`else
        pe_set  = 1'b0;
`endif
    end

    assign io_ready_data = rdy_q;
    assign io_rd_data    = rdata_q;
    assign txd           = txd_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_spart_mmio_bridge.sv
// Directed bench for spart_mmio_bridge: register access, TX framing, loopback, stalls, RX errors, reset.
module tb_spart_mmio_bridge;
    import spart_pkg::*;

`ifdef SPART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int DEPTH = 16;

    logic        clk = 1'b0, rst = 1'b0, io_rw_data = 1'b0, io_valid_data = 1'b0, rxd = 1'b1;
    logic [27:0] mem_addr = '0;
    logic [31:0] io_wr_data = '0;
    logic        io_ready_data, txd, irq;
    logic [31:0] io_rd_data;
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    spart_mmio_bridge #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .DIV_W(16), .DIV_RESET(27)) dut (
        .clk(clk), .rst(rst), .io_rw_data(io_rw_data), .io_valid_data(io_valid_data),
        .io_ready_data(io_ready_data), .mem_addr(mem_addr), .io_wr_data(io_wr_data),
        .io_rd_data(io_rd_data), .rxd(rxd), .txd(txd), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Serial frame bits, LSB sent first.
    function automatic logic [10:0] frame(input logic [7:0] b, input logic stop);
`ifdef SPART_PARITY_EN
        return {stop, ^b, b, 1'b0};
`else
        return {1'b1, stop, b, 1'b0};
`endif
    endfunction

    task automatic bus(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output int waited);
        io_rw_data    = wr;
        mem_addr      = {26'b0, a};
        io_wr_data    = wd;
        io_valid_data = 1'b1;
        waited        = 0;
        rd            = 'x;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            waited++;
            if (io_ready_data) begin
                rd = io_rd_data;
                break;
            end
        end
        if (!io_ready_data) chk("bus_timeout", io_ready_data, 1);
        io_valid_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic wreg(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rd;
        int w;
        bus(1'b1, a, d, rd, w);
    endtask

    task automatic rreg(input logic [1:0] a, output logic [31:0] rd);
        int w;
        bus(1'b0, a, 32'h0, rd, w);
    endtask

    task automatic rchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        rreg(a, rd);
        chk(tag, rd, exp);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [10:0] f;
        f = frame(b, stop);
        for (int i = 0; i < NB; i++) begin
            rxd = f[i];
            repeat (16) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_txd_low();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (txd == 1'b0) break;
        end
        chk("txd_start", txd, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [10:0] fr;
        int w, wmax, idx;

        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_ready", io_ready_data, 0);
        chk("rst_rdata", io_rd_data, 0);
        chk("rst_irq", irq, 0);
        rst = 1'b1;
        @(negedge clk);
        rchk("rst_status", REG_STATUS, 32'h0000_0006);
        rchk("rst_div", REG_DIV, 32'd27);
        rchk("rst_ctrl", REG_CTRL, 32'd0);

        // TX frame shape at one tick per clock
        wreg(REG_DIV, 32'd0);
        wreg(REG_DATA, 32'h0000_00A5);
        wait_txd_low();
        fr = frame(8'hA5, 1'b1);
        for (int k = 1; k <= 16 * NB - 8; k++) begin
            @(negedge clk);
            if (k == 15) chk("tx_start_len15", txd, 0);
            if (k == 16) chk("tx_start_len16", txd, 1);
            if (k % 16 == 8) chk($sformatf("tx_bit%0d", k / 16), txd, fr[k / 16]);
        end
        for (int i = 0; i < 50; i++) begin
            rreg(REG_STATUS, rd);
            if (rd[ST_TX_IDLE]) break;
        end
        chk("tx_idle_after", rd, 32'h0000_0006);

        // Internal loopback
        wreg(REG_CTRL, 32'd4);
        wreg(REG_DATA, 32'h0000_003C);
        wreg(REG_DATA, 32'h0000_00C3);
        repeat (400) @(negedge clk);
        rchk("lb_status", REG_STATUS, 32'h0000_0202);
        wreg(REG_CTRL, 32'd5);
        repeat (3) @(negedge clk);
        chk("irq_rx", irq, 1);
        rchk("lb_rd0", REG_DATA, 32'h0000_003C);
        rchk("lb_rd1", REG_DATA, 32'h0000_00C3);
        rchk("lb_empty", REG_DATA, RD_EMPTY);
        repeat (3) @(negedge clk);
        chk("irq_clear", irq, 0);

        // TX FIFO full stall, bytes looped back
        wreg(REG_CTRL, 32'd4);
        wreg(REG_DIV, 32'd3);
        wmax = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            bus(1'b1, REG_DATA, 32'h10 + i, rd, w);
            if (i < DEPTH + 1 && w > wmax) wmax = w;
        end
        chk("stall_free_wait", wmax, 1);
        chk("stall_held", (w > 300), 1);
        idx = 0;
        for (int it = 0; it < 12000 && idx < DEPTH + 2; it++) begin
            rreg(REG_DATA, rd);
            if (rd != RD_EMPTY) begin
                chk($sformatf("lb_byte%0d", idx), rd, 32'h10 + idx);
                idx++;
            end
        end
        chk("lb_count", idx, DEPTH + 2);
        wreg(REG_CTRL, 32'd0);
        wreg(REG_DIV, 32'd0);

        // RX overrun
        for (int i = 0; i < DEPTH + 1; i++) rx_send(8'h40 + 8'(i), 1'b1);
        rchk("ovr_status1", REG_STATUS, 32'h0000_101A);
        rchk("ovr_status2", REG_STATUS, 32'h0000_100A);
        for (int i = 0; i < DEPTH; i++) rchk($sformatf("ovr_byte%0d", i), REG_DATA, 32'h40 + i);
        rchk("ovr_empty", REG_DATA, RD_EMPTY);

        // Framing error
        rx_send(8'h77, 1'b0);
        rchk("fe_status1", REG_STATUS, 32'h0000_0026);
        rchk("fe_status2", REG_STATUS, 32'h0000_0006);

        // Reset mid-frame
        wreg(REG_DIV, 32'd5);
        wreg(REG_DIV, 32'd0);
        wreg(REG_DATA, 32'h0000_0000);
        wait_txd_low();
        repeat (40) @(negedge clk);
        chk("mid_txd_low", txd, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1);
        chk("mid_rst_ready", io_ready_data, 0);
        chk("mid_rst_rdata", io_rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rchk("post_status", REG_STATUS, 32'h0000_0006);
        rchk("post_div", REG_DIV, 32'd27);
        chk("post_txd", txd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
